// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory req/ack channel plus the
// valid/ready instruction channel toward decode.
interface fetch_unit_if;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] data_inst;
   logic        inst_valid;
   logic        inst_ready;

   // Handshakes: a memory request holds mem_req/mem_addr until the cycle
   // mem_ack is high; an instruction transfers on any rising edge where
   // inst_valid && inst_ready, and data_inst is held stable until then.
   modport master (
      output mem_req, mem_addr, data_inst, inst_valid,
      input  mem_ack, mem_rdata, inst_ready
   );

   modport slave (
      input  mem_req, mem_addr, data_inst, inst_valid,
      output mem_ack, mem_rdata, inst_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch/issue sequencer: PC, memory req/ack fetch, valid/ready issue,
// branch redirect with drain. Optional issue counter under FETCH_PERF_EN.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   fetch_unit_if.master bus,
   input  logic         should_branch,
   input  logic [15:0]  branch_target,
   output logic [15:0]  pc,
   output logic [1:0]   fsm_state
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]  perf_issued
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DRAIN} state_t;

   state_t      state, state_nxt;
   logic [15:0] pc_nxt;
   logic [15:0] drain_addr, drain_addr_nxt;
   logic [15:0] inst_q, inst_nxt;
   logic        handshake;
   logic        mem_ack_i;

   assign mem_ack_i = bus.mem_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         drain_addr <= RESET_PC;
         inst_q     <= 16'h0000;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         drain_addr <= drain_addr_nxt;
         inst_q     <= inst_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      drain_addr_nxt = drain_addr;
      inst_nxt       = inst_q;
      handshake      = (state == ISSUE) && bus.inst_ready;
      case (state)
         IDLE: begin
            if (en) state_nxt = FETCH;
         end
         FETCH: begin
            if (mem_ack_i) begin
               if (should_branch) begin
                  state_nxt = en ? FETCH : IDLE;
               end else begin
                  inst_nxt  = bus.mem_rdata;
                  state_nxt = ISSUE;
               end
            end else if (should_branch) begin
               // Memory still owes a word for the old address: keep asking for it.
               drain_addr_nxt = pc;
               state_nxt      = DRAIN;
            end
         end
         ISSUE: begin
            if (should_branch) begin
               state_nxt = en ? FETCH : IDLE;
            end else if (handshake) begin
               pc_nxt    = pc + 16'd1;
               state_nxt = en ? FETCH : IDLE;
            end
         end
         DRAIN: begin
            if (mem_ack_i) state_nxt = en ? FETCH : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (should_branch) pc_nxt = branch_target;
   end

   assign bus.mem_req    = (state == FETCH) || (state == DRAIN);
   assign bus.mem_addr   = (state == DRAIN) ? drain_addr : pc;
   assign bus.inst_valid = (state == ISSUE);
   assign bus.data_inst  = inst_q;
   assign fsm_state      = state;

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perf_issued <= 16'h0000;
      else if (handshake) perf_issued <= perf_issued + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic checked
// against a program-flow model (expected PC and memory contents).
module tb_fetch_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        en, should_branch;
   logic [15:0] branch_target, pc;
   logic [1:0]  fsm_a;
   logic        en_b, br_b;
   logic [15:0] tgt_b, pc_b;
   logic [1:0]  fsm_b;
`ifdef FETCH_PERF_EN
   logic [15:0] perf_a, perf_b;
`endif

   fetch_unit_if bus_a ();
   fetch_unit_if bus_b ();

   fetch_unit #(.RESET_PC(16'h0010)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .bus(bus_a.master),
      .should_branch(should_branch), .branch_target(branch_target),
      .pc(pc), .fsm_state(fsm_a)
`ifdef FETCH_PERF_EN
      , .perf_issued(perf_a)
`endif
   );

   fetch_unit #(.RESET_PC(16'hFFFF)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .bus(bus_b.master),
      .should_branch(br_b), .branch_target(tgt_b),
      .pc(pc_b), .fsm_state(fsm_b)
`ifdef FETCH_PERF_EN
      , .perf_issued(perf_b)
`endif
   );

   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_pc, issued_cnt, seed_word, req_addr, data_prev, tgt_d;
   logic        en_d, ready_d, br_d;
   logic        req_active, br_prev, valid_prev, acc_prev;
   int          waited, lat, lat_fix;
   logic [6:0]  vpat;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0000: return 16'hA0FE;
         16'h0001: return 16'hA9ED;
         16'h0002: return 16'h2400;
         default:  return (a * 16'h9E37) ^ seed_word;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Called just after a falling edge: outputs are settled.
   task automatic observe();
      if (!rst_n) return;
      chk("pc", pc, exp_pc);
      if (br_prev) chk("valid_after_branch", 16'(bus_a.inst_valid), 16'd0);
      if (valid_prev && !acc_prev && !br_prev && bus_a.inst_valid)
         chk("data_hold", bus_a.data_inst, data_prev);
      if (req_active) begin
         chk("req_hold", 16'(bus_a.mem_req), 16'd1);
         chk("addr_hold", bus_a.mem_addr, req_addr);
      end else if (bus_a.mem_req) begin
         req_active = 1'b1;
         waited     = 0;
         lat        = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
         req_addr   = bus_a.mem_addr;
      end
`ifdef FETCH_PERF_EN
      chk("perf", perf_a, issued_cnt);
`endif
   endtask

   // Applies inputs for the next rising edge and advances the model.
   task automatic drive();
      logic ack, hs;
      ack = req_active && (waited == lat);
      waited++;
      bus_a.mem_ack    = ack;
      bus_a.mem_rdata  = ack ? mem_word(bus_a.mem_addr) : 16'($urandom);
      bus_a.inst_ready = ready_d;
      en               = en_d;
      should_branch    = br_d;
      branch_target    = tgt_d;
      hs = bus_a.inst_valid && ready_d;
      if (hs) begin
         chk("word", bus_a.data_inst, mem_word(exp_pc));
         if (exp_q.size() > 0) chk("sb_word", bus_a.data_inst, exp_q.pop_front());
         issued_cnt = issued_cnt + 16'd1;
      end
      if (br_d) exp_pc = tgt_d;
      else if (hs) exp_pc = exp_pc + 16'd1;
      if (ack) req_active = 1'b0;
      br_prev    = br_d;
      valid_prev = bus_a.inst_valid;
      acc_prev   = hs;
      data_prev  = bus_a.data_inst;
   endtask

   task automatic cycle();
      drive();
      @(negedge clk);
      observe();
   endtask

   task automatic wait_valid(input int budget);
      int n;
      n = budget;
      while (!bus_a.inst_valid && n > 0) begin
         cycle();
         n--;
      end
      chk("valid_timeout", 16'(bus_a.inst_valid), 16'd1);
   endtask

   task automatic start_reset();
      rst_n = 1'b0;
      en = 1'b0; should_branch = 1'b0; branch_target = 16'h0;
      bus_a.mem_ack = 1'b0; bus_a.mem_rdata = 16'h0; bus_a.inst_ready = 1'b0;
      en_b = 1'b0; br_b = 1'b0; tgt_b = 16'h0;
      bus_b.mem_ack = 1'b0; bus_b.mem_rdata = 16'h0; bus_b.inst_ready = 1'b0;
      en_d = 1'b0; ready_d = 1'b0; br_d = 1'b0; tgt_d = 16'h0; lat_fix = -1;
      req_active = 1'b0; br_prev = 1'b0; valid_prev = 1'b0; acc_prev = 1'b0;
      exp_pc = 16'h0010; issued_cnt = 16'h0; exp_q.delete();
   endtask

   task automatic do_reset();
      start_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      seed_word = 16'($urandom);
      start_reset();
      repeat (2) @(negedge clk);
      // reset values
      chk("rst_pc", pc, 16'h0010);
      chk("rst_addr", bus_a.mem_addr, 16'h0010);
      chk("rst_req", 16'(bus_a.mem_req), 16'd0);
      chk("rst_valid", 16'(bus_a.inst_valid), 16'd0);
      chk("rst_data", bus_a.data_inst, 16'h0000);
`ifdef FETCH_PERF_EN
      chk("rst_perf", perf_a, 16'h0000);
`endif
      rst_n = 1'b1;
      en_d = 1'b1;
      cycle();
      chk("en_req", 16'(bus_a.mem_req), 16'd1);
      chk("en_addr", bus_a.mem_addr, 16'h0010);

      // sequential zero-wait fetch from address 0
      do_reset();
      br_d = 1'b1; tgt_d = 16'h0000;
      cycle();
      br_d = 1'b0;
      chk("idle_br_pc", pc, 16'h0000);
      chk("idle_br_req", 16'(bus_a.mem_req), 16'd0);
      exp_q.push_back(16'hA0FE); exp_q.push_back(16'hA9ED); exp_q.push_back(16'h2400);
      en_d = 1'b1; ready_d = 1'b1; lat_fix = 0;
      for (int i = 0; i < 7; i++) begin
         cycle();
         vpat[i] = bus_a.inst_valid;
      end
      chk("seq_valid_pat", 16'(vpat), 16'(7'b0101010));
      chk("seq_pc", pc, 16'h0003);
      chk("seq_sb_left", 16'(exp_q.size()), 16'd0);

      // memory wait states, then decode backpressure
      do_reset();
      lat_fix = 3; en_d = 1'b1; ready_d = 1'b0;
      cycle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("wait_req", 16'(bus_a.mem_req), 16'd1);
         chk("wait_addr", bus_a.mem_addr, 16'h0010);
      end
      cycle();
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("stall_valid", 16'(bus_a.inst_valid), 16'd1);
         chk("stall_data", bus_a.data_inst, mem_word(16'h0010));
         chk("stall_pc", pc, 16'h0010);
      end
      ready_d = 1'b1;
      cycle();
      ready_d = 1'b0;
      chk("stall_release_pc", pc, 16'h0011);

      // branch while a fetch at 0x0005 is pending
      do_reset();
      br_d = 1'b1; tgt_d = 16'h0005;
      cycle();
      br_d = 1'b0; en_d = 1'b1; lat_fix = 2;
      cycle();
      chk("pend_addr", bus_a.mem_addr, 16'h0005);
      br_d = 1'b1; tgt_d = 16'h0040;
      cycle();
      br_d = 1'b0;
      chk("drain_req", 16'(bus_a.mem_req), 16'd1);
      chk("drain_addr", bus_a.mem_addr, 16'h0005);
      exp_q.push_back(mem_word(16'h0040));
      cycle();
      cycle();
      chk("redirect_req", 16'(bus_a.mem_req), 16'd1);
      chk("redirect_addr", bus_a.mem_addr, 16'h0040);
      lat_fix = -1; ready_d = 1'b1;
      wait_valid(20);
      // branch coinciding with the issue handshake
      br_d = 1'b1; tgt_d = 16'h0100;
      cycle();
      br_d = 1'b0;
      chk("br_issue_req", 16'(bus_a.mem_req), 16'd1);
      chk("br_issue_addr", bus_a.mem_addr, 16'h0100);
      chk("br_issue_sb_left", 16'(exp_q.size()), 16'd0);
`ifdef FETCH_PERF_EN
      chk("br_issue_perf", perf_a, 16'h0001);
`endif

      // en dropped during FETCH: word still issued, then park
      do_reset();
      en_d = 1'b1; lat_fix = 2;
      cycle();
      en_d = 1'b0;
      wait_valid(10);
      chk("park_data", bus_a.data_inst, mem_word(16'h0010));
      ready_d = 1'b1;
      cycle();
      ready_d = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("park_req", 16'(bus_a.mem_req), 16'd0);
         chk("park_valid", 16'(bus_a.inst_valid), 16'd0);
      end
      chk("park_pc", pc, 16'h0011);

      // reset asserted between edges abandons the request at once
      do_reset();
      en_d = 1'b1; lat_fix = 3;
      cycle();
      #2 rst_n = 1'b0;
      #1 chk("async_req", 16'(bus_a.mem_req), 16'd0);
      chk("async_pc", pc, 16'h0010);

      // randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         en_d    = ($urandom_range(0, 9) != 0);
         ready_d = ($urandom_range(0, 2) != 0);
         br_d    = ($urandom_range(0, 11) == 0);
         tgt_d   = 16'($urandom);
         cycle();
      end
      chk("rand_progress", 16'(issued_cnt > 16'd50), 16'd1);

      // PC wrap on the 0xFFFF-reset instance
      do_reset();
      en_b = 1'b1;
      @(negedge clk);
      chk("wrap_req", 16'(bus_b.mem_req), 16'd1);
      chk("wrap_addr", bus_b.mem_addr, 16'hFFFF);
      bus_b.mem_ack = 1'b1; bus_b.mem_rdata = 16'h1234;
      @(negedge clk);
      bus_b.mem_ack = 1'b0;
      chk("wrap_valid", 16'(bus_b.inst_valid), 16'd1);
      chk("wrap_data", bus_b.data_inst, 16'h1234);
      bus_b.inst_ready = 1'b1;
      @(negedge clk);
      bus_b.inst_ready = 1'b0; en_b = 1'b0;
      chk("wrap_pc", pc_b, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
